// File: rtl/xy_avg_readout.sv
// xy_avg_readout: block averager between the lock-in core X/Y outputs and the
// GPIO readback mux. Accumulates 2^k signed X/Y pairs, divides by an
// arithmetic right shift (floor) and holds the result until software acks it.
// Optional feature: define XY_AVG_DROP_CNT_EN to build the dropped-sample
// counter. Without it, drop_cnt is tied to zero.
module xy_avg_readout #(
    parameter int DATA_WIDTH   = 32,
    parameter int LOG2_MAX_AVG = 10,
    parameter int DROP_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    input  logic                         in_valid,
    input  logic        [3:0]            avg_shift,
    input  logic                         cont,
    input  logic                         arm,
    input  logic                         clr,
    input  logic                         rd_ack,
    output logic signed [DATA_WIDTH-1:0] x_avg,
    output logic signed [DATA_WIDTH-1:0] y_avg,
    output logic                         avg_valid,
    output logic                         busy,
    output logic        [DROP_WIDTH-1:0] drop_cnt
);

    localparam int ACC_W = DATA_WIDTH + LOG2_MAX_AVG;
    localparam int CNT_W = LOG2_MAX_AVG + 1;

    // S_FINAL is the one-cycle divide stage; externally it still reads as
    // busy, so software sees IDLE / ACCUM / HOLD only.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                         state_r;
    state_t                         state_n_s;
    logic signed [ACC_W-1:0]        acc_x_r;
    logic signed [ACC_W-1:0]        acc_y_r;
    logic signed [ACC_W-1:0]        acc_x_shift_s;
    logic signed [ACC_W-1:0]        acc_y_shift_s;
    logic        [CNT_W-1:0]        cnt_r;
    logic        [CNT_W-1:0]        last_idx_s;
    logic        [3:0]              k_lat_r;
    logic        [3:0]              k_clamp_s;
    logic signed [DATA_WIDTH-1:0]   x_avg_r;
    logic signed [DATA_WIDTH-1:0]   y_avg_r;
    logic                           avg_valid_r;
    logic                           busy_r;
    logic                           start_s;
    logic                           take_s;
    logic                           publish_s;
    logic                           release_s;
    logic                           abort_s;

    // Averaging exponent clamp, last-sample index and the divide shift.
    always_comb begin
        k_clamp_s = avg_shift;
        if (avg_shift > 4'(LOG2_MAX_AVG)) begin
            k_clamp_s = 4'(LOG2_MAX_AVG);
        end else begin
            k_clamp_s = avg_shift;
        end
        last_idx_s    = (CNT_W'(1) << k_lat_r) - CNT_W'(1);
        acc_x_shift_s = acc_x_r >>> k_lat_r;
        acc_y_shift_s = acc_y_r >>> k_lat_r;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic and the datapath control strobes; clr has top priority.
    always_comb begin
        state_n_s = state_r;
        start_s   = 1'b0;
        take_s    = 1'b0;
        publish_s = 1'b0;
        release_s = 1'b0;
        abort_s   = 1'b0;
        if (clr) begin
            state_n_s = S_IDLE;
            abort_s   = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arm) begin
                        state_n_s = S_ACCUM;
                        start_s   = 1'b1;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        take_s = 1'b1;
                        if (cnt_r == last_idx_s) begin
                            state_n_s = S_FINAL;
                        end else begin
                            state_n_s = S_ACCUM;
                        end
                    end else begin
                        state_n_s = S_ACCUM;
                    end
                end
                S_FINAL: begin
                    publish_s = 1'b1;
                    state_n_s = S_HOLD;
                end
                S_HOLD: begin
                    if (rd_ack) begin
                        release_s = 1'b1;
                        if (cont) begin
                            state_n_s = S_ACCUM;
                            start_s   = 1'b1;
                        end else begin
                            state_n_s = S_IDLE;
                        end
                    end else begin
                        state_n_s = S_HOLD;
                    end
                end
                default: begin
                    state_n_s = S_IDLE;
                    abort_s   = 1'b1;
                end
            endcase
        end
    end

    // Accumulators, sample counter, latched exponent and held result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_x_r     <= {ACC_W{1'b0}};
            acc_y_r     <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            k_lat_r     <= 4'd0;
            x_avg_r     <= {DATA_WIDTH{1'b0}};
            y_avg_r     <= {DATA_WIDTH{1'b0}};
            avg_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_n_s == S_ACCUM) || (state_n_s == S_FINAL);
            if (abort_s) begin
                acc_x_r     <= {ACC_W{1'b0}};
                acc_y_r     <= {ACC_W{1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                avg_valid_r <= 1'b0;
            end else if (start_s) begin
                acc_x_r     <= {ACC_W{1'b0}};
                acc_y_r     <= {ACC_W{1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                k_lat_r     <= k_clamp_s;
                avg_valid_r <= 1'b0;
            end else if (take_s) begin
                acc_x_r <= acc_x_r + {{LOG2_MAX_AVG{x_in[DATA_WIDTH-1]}}, x_in};
                acc_y_r <= acc_y_r + {{LOG2_MAX_AVG{y_in[DATA_WIDTH-1]}}, y_in};
                cnt_r   <= cnt_r + CNT_W'(1);
            end else if (publish_s) begin
                x_avg_r     <= acc_x_shift_s[DATA_WIDTH-1:0];
                y_avg_r     <= acc_y_shift_s[DATA_WIDTH-1:0];
                avg_valid_r <= 1'b1;
            end else if (release_s) begin
                avg_valid_r <= 1'b0;
            end else begin
                avg_valid_r <= avg_valid_r;
            end
        end
    end

`ifdef XY_AVG_DROP_CNT_EN
    logic [DROP_WIDTH-1:0] drop_cnt_r;

    // Saturating count of samples that arrive while a result is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= {DROP_WIDTH{1'b0}};
        end else if (abort_s) begin
            drop_cnt_r <= {DROP_WIDTH{1'b0}};
        end else if ((state_r == S_HOLD) && in_valid && (drop_cnt_r != {DROP_WIDTH{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_WIDTH'(1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = {DROP_WIDTH{1'b0}};
`endif

    assign x_avg     = x_avg_r;
    assign y_avg     = y_avg_r;
    assign avg_valid = avg_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_xy_avg_readout.sv
// Directed bench for xy_avg_readout: an abstract sample-list model checked
// every cycle, plus hand-computed literal expectations.
module tb_xy_avg_readout;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] x_in = 32'sd0;
    logic signed [31:0] y_in = 32'sd0;
    logic               in_valid = 1'b0;
    logic        [3:0]  avg_shift = 4'd0;
    logic               cont = 1'b0;
    logic               arm = 1'b0;
    logic               clr = 1'b0;
    logic               rd_ack = 1'b0;
    logic signed [31:0] x_avg;
    logic signed [31:0] y_avg;
    logic               avg_valid;
    logic               busy;
    logic        [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    xy_avg_readout dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .in_valid(in_valid),
        .avg_shift(avg_shift), .cont(cont), .arm(arm), .clr(clr), .rd_ack(rd_ack),
        .x_avg(x_avg), .y_avg(y_avg), .avg_valid(avg_valid), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by 2^k using plain integer arithmetic.
    function automatic longint floor_div(input longint sum, input int k);
        longint n;
        longint q;
        n = longint'(1) << k;
        q = sum / n;
        if ((sum % n != 0) && (sum < 0)) q = q - 1;
        return q;
    endfunction

    // Model: 0 idle, 1 collecting, 2 dividing, 3 holding.
    int     m_mode;
    int     m_n;
    int     m_k;
    longint m_sum_x, m_sum_y;
    longint exp_x, exp_y;
    int     exp_drop;
    bit     exp_valid;
    bit     drop_en;

    initial begin
`ifdef XY_AVG_DROP_CNT_EN
        drop_en = 1'b1;
`else
        drop_en = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_n <= 0; m_k <= 0; m_sum_x <= 0; m_sum_y <= 0;
            exp_x <= 0; exp_y <= 0; exp_valid <= 1'b0; exp_drop <= 0;
        end else if (clr) begin
            m_mode <= 0; m_n <= 0; m_sum_x <= 0; m_sum_y <= 0;
            exp_valid <= 1'b0; exp_drop <= 0;
        end else begin
            case (m_mode)
                0: if (arm) begin
                    m_mode <= 1; m_n <= 0; m_sum_x <= 0; m_sum_y <= 0;
                    m_k <= (avg_shift > 4'd10) ? 10 : int'(avg_shift);
                end
                1: if (in_valid) begin
                    m_sum_x <= m_sum_x + longint'(x_in);
                    m_sum_y <= m_sum_y + longint'(y_in);
                    m_n <= m_n + 1;
                    if (m_n + 1 == (1 << m_k)) m_mode <= 2;
                end
                2: begin
                    exp_x <= floor_div(m_sum_x, m_k);
                    exp_y <= floor_div(m_sum_y, m_k);
                    exp_valid <= 1'b1;
                    m_mode <= 3;
                end
                default: begin
                    if (in_valid && drop_en && exp_drop < 65535) exp_drop <= exp_drop + 1;
                    if (rd_ack) begin
                        exp_valid <= 1'b0;
                        if (cont) begin
                            m_mode <= 1; m_n <= 0; m_sum_x <= 0; m_sum_y <= 0;
                            m_k <= (avg_shift > 4'd10) ? 10 : int'(avg_shift);
                        end else begin
                            m_mode <= 0;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("x_avg", longint'(x_avg), exp_x);
            check("y_avg", longint'(y_avg), exp_y);
            check("avg_valid", longint'(avg_valid), longint'(exp_valid));
            check("busy", longint'(busy), longint'((m_mode == 1) || (m_mode == 2)));
            check("drop_cnt", longint'(drop_cnt), longint'(exp_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int x, input int y);
        in_valid = 1'b1; x_in = x; y_in = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_x_avg", longint'(x_avg), 0);
        check("rst_valid", longint'(avg_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_drop", longint'(drop_cnt), 0);
        #20 rst = 1'b1;
        tick();

        // N=4 single shot: (10+20+30+41)/4 = 25.25 -> 25
        avg_shift = 4'd2; cont = 1'b0;
        pulse_arm();
        check("arm_busy", longint'(busy), 1);
        sample(10, 0); sample(20, 0); sample(30, 0); sample(41, 0);
        check("n4_not_yet", longint'(avg_valid), 0);
        tick();
        check("n4_x", longint'(x_avg), 25);
        check("n4_valid", longint'(avg_valid), 1);
        check("n4_busy", longint'(busy), 0);
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        check("n4_ack_valid", longint'(avg_valid), 0);
        check("n4_ack_busy", longint'(busy), 0);
        tick();

        // k=1 floor: Y = -3,-4 -> -4 ; X = 5,6 -> 5
        avg_shift = 4'd1;
        pulse_arm();
        sample(5, -3); sample(6, -4);
        tick();
        check("floor_y", longint'(y_avg), -4);
        check("floor_x", longint'(x_avg), 5);
        pulse_ack();

        // avg_shift=15 clamps to 10: 1024 strobes; avg_shift change ignored
        avg_shift = 4'd15;
        pulse_arm();
        avg_shift = 4'd0;
        for (int i = 0; i < 1023; i++) sample(100, -1);
        tick(); tick();
        check("clamp_1023", longint'(avg_valid), 0);
        check("clamp_busy", longint'(busy), 1);
        sample(100, -1);
        tick();
        check("clamp_1024", longint'(avg_valid), 1);
        check("clamp_x", longint'(x_avg), 100);
        check("clamp_y", longint'(y_avg), -1);
        pulse_ack();

        // cont=1, N=2, 5 drops in HOLD, then auto re-arm
        avg_shift = 4'd1; cont = 1'b1;
        pulse_arm();
        sample(1, 2); sample(3, 2);
        tick();
        check("cont_x", longint'(x_avg), 2);
        for (int i = 0; i < 5; i++) sample(999, 999);
        check("drop5", longint'(drop_cnt), drop_en ? 5 : 0);
        pulse_ack();
        check("rearm_busy", longint'(busy), 1);
        check("rearm_valid", longint'(avg_valid), 0);
        sample(8, 0); sample(9, 0);
        tick();
        check("cont2_x", longint'(x_avg), 8);
        cont = 1'b0;
        pulse_ack();

        // clr and arm together: stays idle, drop counter cleared
        clr = 1'b1; arm = 1'b1; tick(); clr = 1'b0; arm = 1'b0;
        check("clr_arm_busy", longint'(busy), 0);
        check("clr_drop", longint'(drop_cnt), 0);
        tick();

        // clr after 3 of 8 samples, then a fresh block of 8 x 7
        avg_shift = 4'd3;
        pulse_arm();
        sample(100, 100); sample(100, 100); sample(100, 100);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_mid_busy", longint'(busy), 0);
        check("clr_keep_x", longint'(x_avg), 8);
        pulse_arm();
        for (int i = 0; i < 8; i++) sample(7, -7);
        tick();
        check("after_clr_x", longint'(x_avg), 7);
        check("after_clr_y", longint'(y_avg), -7);
        check("after_clr_valid", longint'(avg_valid), 1);

        // asynchronous reset in HOLD
        #2 rst = 1'b0;
        #1;
        check("async_valid", longint'(avg_valid), 0);
        check("async_x", longint'(x_avg), 0);
        check("async_busy", longint'(busy), 0);
        #3 rst = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
